// File: rtl/mc_mem_responder.sv
// Memory responder: 64-bit word store, loads returned through a fixed-latency pipeline and response FIFO.
// Optional address/overflow checking is enabled by defining MC_MEM_RESPONDER_CHK_EN.
module mc_mem_responder #(
    parameter int ADDR_W    = 8,
    parameter int LATENCY   = 4,
    parameter int RSP_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mc_req_ld_i,
    input  logic        mc_req_st_i,
    input  logic [47:0] mc_req_vadr_i,
    input  logic [63:0] mc_req_wrd_rdctl_i,
    output logic        mc_req_stall_o,
    output logic        mc_rsp_push_o,
    output logic [31:0] mc_rsp_rdctl_o,
    output logic [63:0] mc_rsp_data_o,
    input  logic        mc_rsp_stall_i,
    output logic        err_o
);

    localparam int MEM_DEPTH = 1 << ADDR_W;
    localparam int PTR_W     = $clog2(RSP_DEPTH);
    localparam int CNT_W     = PTR_W + 1;

    logic [63:0]        mem_q [MEM_DEPTH];
    logic [ADDR_W-1:0]  req_idx;
    logic [63:0]        rd_word;

    logic [LATENCY-1:0] pipe_vld_q;
    logic [31:0]        pipe_tag_q  [LATENCY];
    logic [63:0]        pipe_data_q [LATENCY];

    logic [31:0]        fifo_tag_q  [RSP_DEPTH];
    logic [63:0]        fifo_data_q [RSP_DEPTH];
    logic [PTR_W:0]     wr_ptr_q, rd_ptr_q;
    logic               fifo_empty, fifo_full, fifo_push, fifo_pop;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ld_accept;
    logic               stall_q, push_q;
    logic [31:0]        rdctl_q;
    logic [63:0]        data_q;

    assign req_idx = mc_req_vadr_i[ADDR_W+2:3];
    assign rd_word = mem_q[req_idx];

    // Memory is never reset so contents survive a mid-operation reset.
    always_ff @(posedge clk) begin
        if (!rst && mc_req_st_i) begin
            mem_q[req_idx] <= mc_req_wrd_rdctl_i;
        end
    end

    // The outstanding count covers pipeline plus FIFO, so the FIFO can never overflow.
    assign ld_accept  = mc_req_ld_i && (cnt_q != CNT_W'(RSP_DEPTH));
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign fifo_push  = pipe_vld_q[LATENCY-1] && !fifo_full;
    assign fifo_pop   = !fifo_empty && !mc_rsp_stall_i;

    always_comb begin
        cnt_d = cnt_q;
        if (ld_accept && !fifo_pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!ld_accept && fifo_pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_q <= '0;
        end else begin
            pipe_vld_q[0] <= ld_accept;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        pipe_tag_q[0]  <= mc_req_wrd_rdctl_i[31:0];
        pipe_data_q[0] <= rd_word;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_tag_q[i]  <= pipe_tag_q[i-1];
            pipe_data_q[i] <= pipe_data_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_tag_q[wr_ptr_q[PTR_W-1:0]]  <= pipe_tag_q[LATENCY-1];
            fifo_data_q[wr_ptr_q[PTR_W-1:0]] <= pipe_data_q[LATENCY-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            stall_q  <= 1'b0;
            push_q   <= 1'b0;
            rdctl_q  <= '0;
            data_q   <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
            end
            cnt_q   <= cnt_d;
            stall_q <= (cnt_d >= CNT_W'(RSP_DEPTH - 2));
            push_q  <= fifo_pop;
            rdctl_q <= fifo_pop ? fifo_tag_q[rd_ptr_q[PTR_W-1:0]]  : 32'd0;
            data_q  <= fifo_pop ? fifo_data_q[rd_ptr_q[PTR_W-1:0]] : 64'd0;
        end
    end

    assign mc_req_stall_o = stall_q;
    assign mc_rsp_push_o  = push_q;
    assign mc_rsp_rdctl_o = rdctl_q;
    assign mc_rsp_data_o  = data_q;

`ifdef MC_MEM_RESPONDER_CHK_EN
    logic addr_bad, ld_drop, err_q;

    assign addr_bad = (mc_req_vadr_i[2:0] != 3'd0) || (mc_req_vadr_i[47:ADDR_W+3] != '0);
    assign ld_drop  = mc_req_ld_i && !ld_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (((mc_req_ld_i || mc_req_st_i) && addr_bad) || ld_drop) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mc_req_vadr_i[47:ADDR_W+3], mc_req_vadr_i[2:0]};
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mc_mem_responder.sv
// Directed bench for mc_mem_responder: driver tasks push expected responses, a monitor pops and compares.
module tb_mc_mem_responder;

    localparam int LAT = 4;
`ifdef MC_MEM_RESPONDER_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_ld = 1'b0;
    logic        req_st = 1'b0;
    logic [47:0] req_vadr = '0;
    logic [63:0] req_wrd = '0;
    logic        req_stall;
    logic        rsp_push;
    logic [31:0] rsp_rdctl;
    logic [63:0] rsp_data;
    logic        rsp_stall = 1'b0;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int push_count = 0;

    logic [31:0] exp_tag_q[$];
    logic [63:0] exp_data_q[$];
    int          exp_cyc_q[$];

    mc_mem_responder #(.ADDR_W(8), .LATENCY(LAT), .RSP_DEPTH(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .mc_req_ld_i       (req_ld),
        .mc_req_st_i       (req_st),
        .mc_req_vadr_i     (req_vadr),
        .mc_req_wrd_rdctl_i(req_wrd),
        .mc_req_stall_o    (req_stall),
        .mc_rsp_push_o     (rsp_push),
        .mc_rsp_rdctl_o    (rsp_rdctl),
        .mc_rsp_data_o     (rsp_data),
        .mc_rsp_stall_i    (rsp_stall),
        .err_o             (err)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rsp_push === 1'b1) begin
            push_count++;
            if (exp_tag_q.size() == 0) begin
                chk("unexpected_push", 64'(rsp_rdctl), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                logic [31:0] et;
                logic [63:0] ed;
                int          ec;
                et = exp_tag_q.pop_front();
                ed = exp_data_q.pop_front();
                ec = exp_cyc_q.pop_front();
                chk("rsp_rdctl", 64'(rsp_rdctl), 64'(et));
                chk("rsp_data", rsp_data, ed);
                if (ec != 0) chk("rsp_latency", 64'(cyc), 64'(ec));
            end
        end else begin
            chk("idle_rsp_zero", {rsp_rdctl, rsp_data[31:0]} | 64'(rsp_data[63:32]), 64'd0);
        end
    end

    // driver tasks
    task automatic drive(input logic ld, input logic st, input logic [47:0] vadr,
                         input logic [63:0] wrd, input logic [63:0] exp_data,
                         input bit expect_rsp, input bit chk_lat);
        @(negedge clk);
        req_ld   = ld;
        req_st   = st;
        req_vadr = vadr;
        req_wrd  = wrd;
        if (ld && expect_rsp) begin
            exp_tag_q.push_back(wrd[31:0]);
            exp_data_q.push_back(exp_data);
            exp_cyc_q.push_back(chk_lat ? cyc + 1 + LAT + 1 : 0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_ld   = 1'b0;
            req_st   = 1'b0;
            req_vadr = '0;
            req_wrd  = '0;
        end
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int n = 0;
        while (exp_tag_q.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk(name, 64'(exp_tag_q.size()), 64'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int pc;

        // reset: outputs cleared
        repeat (3) @(negedge clk);
        chk("rst_stall", 64'(req_stall), 64'd0);
        chk("rst_push", 64'(rsp_push), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst = 1'b0;

        // seed words, then a reset carrying a store and load that must be ignored
        drive(1, 0, 48'h0, 64'h0, 64'h0, 0, 0);
        req_ld = 1'b0;
        req_st = 1'b1; req_vadr = 48'h28; req_wrd = 64'h1111_2222_3333_4444;
        drive(0, 1, 48'h0, 64'h0F0F_0F0F_F0F0_F0F0, 64'h0, 0, 0);
        idle(1);
        @(negedge clk);
        rst = 1'b1;
        req_ld = 1'b1; req_st = 1'b1; req_vadr = 48'h28; req_wrd = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        rst = 1'b0;
        req_ld = 1'b0; req_st = 1'b0; req_vadr = '0; req_wrd = '0;
        chk("rst2_stall", 64'(req_stall), 64'd0);
        chk("rst2_err", 64'(err), 64'd0);
        drive(1, 0, 48'h28, 64'h77, 64'h1111_2222_3333_4444, 1, 1);
        idle(1);
        wait_drain("drain_rst_store", 30);

        // store then load, exact latency
        drive(0, 1, 48'h10, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 0);
        drive(1, 0, 48'h10, 64'h5, 64'h0123_4567_89AB_CDEF, 1, 1);
        idle(1);
        wait_drain("drain_basic", 30);

        // same-cycle store and load: read-before-write
        drive(0, 1, 48'h18, 64'h55, 64'h0, 0, 0);
        drive(1, 1, 48'h18, 64'hAA_0000_0036, 64'h55, 1, 1);
        drive(1, 0, 48'h18, 64'h37, 64'hAA_0000_0036, 1, 1);
        idle(1);
        wait_drain("drain_rbw", 30);

        // eight back-to-back loads, in order, no back-pressure
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 48'((8 + i) * 8), {48'hA5A5_0000_0000, 16'(i)}, 64'h0, 0, 0);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 48'((8 + i) * 8), 64'(i), {48'hA5A5_0000_0000, 16'(i)}, 1, 1);
        end
        idle(1);
        wait_drain("drain_b2b", 40);
        chk("b2b_err", 64'(err), 64'd0);

        // response back-pressure: 10 loads, last two dropped
        @(negedge clk);
        rsp_stall = 1'b1;
        pc = push_count;
        for (int k = 0; k <= 10; k++) begin
            int acc;
            @(negedge clk);
            acc = (k < 8) ? k : 8;
            chk($sformatf("req_stall_after_%0d", k), 64'(req_stall), 64'(acc >= 6));
            if (k < 10) begin
                req_ld = 1'b1; req_st = 1'b0;
                req_vadr = 48'((8 + (k % 8)) * 8);
                req_wrd  = 64'(32'h100 + k);
                if (k < 8) begin
                    exp_tag_q.push_back(32'h100 + k);
                    exp_data_q.push_back({48'hA5A5_0000_0000, 16'(k % 8)});
                    exp_cyc_q.push_back(0);
                end
            end else begin
                req_ld = 1'b0; req_vadr = '0; req_wrd = '0;
            end
        end
        chk("drop_err", 64'(err), 64'(CHK));
        idle(5);
        chk("no_push_while_stalled", 64'(push_count - pc), 64'd0);
        rsp_stall = 1'b0;
        pc = push_count;
        wait_drain("drain_stalled", 40);
        idle(3);
        chk("pushes_after_release", 64'(push_count - pc), 64'd8);
        chk("stall_after_release", 64'(req_stall), 64'd0);

        // reset with loads in flight
        @(negedge clk);
        rsp_stall = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(1, 0, 48'h10, 64'(32'h200 + i), 64'h0, 0, 0);
        end
        idle(1);
        chk("pre_reset_stall", 64'(req_stall), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rsp_stall = 1'b0;
        chk("post_reset_stall", 64'(req_stall), 64'd0);
        chk("post_reset_err", 64'(err), 64'd0);
        pc = push_count;
        idle(12);
        chk("post_reset_no_push", 64'(push_count - pc), 64'd0);
        drive(1, 0, 48'h10, 64'h301, 64'h0123_4567_89AB_CDEF, 1, 1);
        drive(1, 0, 48'h18, 64'h302, 64'hAA_0000_0036, 1, 1);
        idle(1);
        wait_drain("drain_retained", 30);

        // misaligned load reads truncated index
        drive(1, 0, 48'h4, 64'h38, 64'h0F0F_0F0F_F0F0_F0F0, 1, 1);
        idle(1);
        chk("misalign_err", 64'(err), 64'(CHK));
        wait_drain("drain_misalign", 30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
